// File: rtl/ls299_shift_reg.sv
// 74LS299 8-bit universal shift/storage register, modelled against an FPGA system clock.
// The TTL clock pin is sampled on clk and either edge-detected or used as a clock enable.
module ls299_shift_reg #(
    parameter bit CP_EDGE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cp,
    input  logic       s0,
    input  logic       s1,
    input  logic       ds0,
    input  logic       ds7,
    input  logic       oe1_n,
    input  logic       oe2_n,
    input  logic [7:0] d_in,
    output logic [7:0] q_out,
    output logic       q_oe,
    output logic       q0,
    output logic       q7
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [7:0] reg_q;
    logic [7:0] reg_d;
    logic       cp_prev_q;
    logic       cp_event;
    mode_e      mode;

    function automatic logic [7:0] next_contents(
        input mode_e      m,
        input logic [7:0] cur,
        input logic       sr_in,
        input logic       sl_in,
        input logic [7:0] par
    );
        logic [7:0] nxt;
        nxt = cur;
        unique case (m)
            MODE_HOLD: nxt = cur;
            MODE_SHR:  nxt = {cur[6:0], sr_in};
            MODE_SHL:  nxt = {sl_in, cur[7:1]};
            MODE_LOAD: nxt = par;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

    assign mode = mode_e'({s1, s0});

    // cp_prev_q resets high so a cp already high at reset release is not an edge.
    assign cp_event = CP_EDGE ? (cp & ~cp_prev_q) : cp;

    always_comb begin
        reg_d = reg_q;
        if (cp_event) begin
            reg_d = next_contents(mode, reg_q, ds0, ds7, d_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q     <= 8'h00;
            cp_prev_q <= 1'b1;
        end else begin
            reg_q     <= reg_d;
            cp_prev_q <= cp;
        end
    end

    // In load mode the physical I/O pins are inputs, so the drive is withdrawn.
    assign q_oe  = ~oe1_n & ~oe2_n & ~(s1 & s0);
    assign q_out = reg_q;
    assign q0    = reg_q[0];
    assign q7    = reg_q[7];

endmodule

// File: tb/tb_ls299_shift_reg.sv
// Bench for ls299_shift_reg: directed scenarios plus randomized traffic against a
// behavioural model, run on an edge-triggered and a level-enabled instance in parallel.
module tb_ls299_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cp;
    logic       s0;
    logic       s1;
    logic       ds0;
    logic       ds7;
    logic       oe1_n;
    logic       oe2_n;
    logic [7:0] d_in;

    logic [7:0] q_out_e;
    logic       q_oe_e;
    logic       q0_e;
    logic       q7_e;
    logic [7:0] q_out_l;
    logic       q_oe_l;
    logic       q0_l;
    logic       q7_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: register contents of each instance, and last sampled cp.
    logic [7:0] m_e;
    logic [7:0] m_l;
    logic       m_cp_prev;

    ls299_shift_reg #(.CP_EDGE(1'b1)) u_dut_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .cp    (cp),
        .s0    (s0),
        .s1    (s1),
        .ds0   (ds0),
        .ds7   (ds7),
        .oe1_n (oe1_n),
        .oe2_n (oe2_n),
        .d_in  (d_in),
        .q_out (q_out_e),
        .q_oe  (q_oe_e),
        .q0    (q0_e),
        .q7    (q7_e)
    );

    ls299_shift_reg #(.CP_EDGE(1'b0)) u_dut_lvl (
        .clk   (clk),
        .rst_n (rst_n),
        .cp    (cp),
        .s0    (s0),
        .s1    (s1),
        .ds0   (ds0),
        .ds7   (ds7),
        .oe1_n (oe1_n),
        .oe2_n (oe2_n),
        .d_in  (d_in),
        .q_out (q_out_l),
        .q_oe  (q_oe_l),
        .q0    (q0_l),
        .q7    (q7_l)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Register update from the mode table, with plain arithmetic on the word.
    function automatic logic [7:0] apply_mode(input logic [7:0] r);
        int v;
        v = int'(r);
        case ({s1, s0})
            2'b01:   v = ((v * 2) + int'(ds0)) % 256;
            2'b10:   v = (v / 2) + (ds7 ? 128 : 0);
            2'b11:   v = int'(d_in);
            default: v = v;
        endcase
        return 8'(v);
    endfunction

    task automatic model_reset();
        m_e       = 8'h00;
        m_l       = 8'h00;
        m_cp_prev = 1'b1;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (cp && !m_cp_prev) m_e = apply_mode(m_e);
            if (cp) m_l = apply_mode(m_l);
            m_cp_prev = cp;
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_oe;
        exp_oe = ~oe1_n & ~oe2_n & ~(s1 & s0);
        check_eq({tag, ".e.q_out"}, q_out_e, m_e);
        check_eq({tag, ".e.q0"}, 8'(q0_e), 8'(m_e[0]));
        check_eq({tag, ".e.q7"}, 8'(q7_e), 8'(m_e[7]));
        check_eq({tag, ".e.q_oe"}, 8'(q_oe_e), 8'(exp_oe));
        check_eq({tag, ".l.q_out"}, q_out_l, m_l);
        check_eq({tag, ".l.q0"}, 8'(q0_l), 8'(m_l[0]));
        check_eq({tag, ".l.q7"}, 8'(q7_l), 8'(m_l[7]));
        check_eq({tag, ".l.q_oe"}, 8'(q_oe_l), 8'(exp_oe));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic pulse(input string tag);
        cp = 1'b0;
        cyc(tag);
        cp = 1'b1;
        cyc(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
    endtask

    task automatic set_mode(input logic [1:0] s);
        s1 = s[1];
        s0 = s[0];
    endtask

    task automatic load(input logic [7:0] v);
        set_mode(2'b11);
        d_in = v;
        pulse("load");
    endtask

    initial begin
        logic [8:0] ones;
        rst_n = 1'b1;
        cp    = 1'b0;
        s0    = 1'b0;
        s1    = 1'b0;
        ds0   = 1'b0;
        ds7   = 1'b0;
        oe1_n = 1'b0;
        oe2_n = 1'b0;
        d_in  = 8'h00;
        model_reset();

        // Reset mid-cycle after some content has been loaded.
        rst_n = 1'b0;
        cyc("rst");
        rst_n = 1'b1;
        load(8'h5A);
        check_eq("pre_rst", q_out_e, 8'h5A);
        async_reset("async_rst");
        check_eq("rst_q_out", q_out_e, 8'h00);
        check_eq("rst_q7", 8'(q7_e), 8'h00);

        // Release with cp high, load mode, d_in=FF: no edge until cp drops and rises.
        cp = 1'b1;
        set_mode(2'b11);
        d_in = 8'hFF;
        cyc("rst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc("rel_hold");
        check_eq("rel_no_edge", q_out_e, 8'h00);
        pulse("rel_edge");
        check_eq("rel_edge_ff", q_out_e, 8'hFF);

        // Load A5 and check enable gating.
        d_in = 8'hA5;
        pulse("ld_a5");
        check_eq("ld_a5", q_out_e, 8'hA5);
        check_eq("ld_oe_off", 8'(q_oe_e), 8'h00);
        set_mode(2'b00);
        #1;
        check_eq("oe_on", 8'(q_oe_e), 8'h01);
        oe2_n = 1'b1;
        #1;
        check_eq("oe2_off", 8'(q_oe_e), 8'h00);
        check_eq("oe2_hold", q_out_e, 8'hA5);
        oe2_n = 1'b0;
        cyc("hold");

        // Shift right filling with ones.
        load(8'h00);
        set_mode(2'b01);
        ds0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pulse("shr");
            ones = (9'h001 << (k + 1)) - 9'h001;
            check_eq("shr_word", q_out_e, ones[7:0]);
            check_eq("shr_q7", 8'(q7_e), (k == 7) ? 8'h01 : 8'h00);
        end
        // One more edge with a zero entering: all-ones detector would release.
        ds0 = 1'b0;
        pulse("shr9");
        check_eq("shr9_fe", q_out_e, 8'hFE);

        // Shift left a single one out through q0.
        load(8'h80);
        set_mode(2'b10);
        ds7 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            pulse("shl");
            check_eq("shl_word", q_out_e, 8'h80 >> (k + 1));
            check_eq("shl_q0", 8'(q0_e), (k == 6) ? 8'h01 : 8'h00);
        end

        // cp held high for 20 clocks: one shift on the edge instance, 20 on the level one.
        load(8'h01);
        set_mode(2'b01);
        ds0 = 1'b0;
        cp = 1'b0;
        cyc("held_pre");
        cp = 1'b1;
        for (int i = 0; i < 20; i++) cyc("held");
        check_eq("held_edge", q_out_e, 8'h02);
        check_eq("held_lvl", q_out_l, 8'h00);
        cp = 1'b0;
        cyc("held_post");

        // Randomized traffic, with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            if (!rst_n && ($urandom_range(0, 3) == 0)) rst_n = 1'b1;
            if ($urandom_range(0, 2) == 0) cp = ~cp;
            {s1, s0} = 2'($urandom_range(0, 3));
            ds0   = 1'($urandom);
            ds7   = 1'($urandom);
            oe1_n = ($urandom_range(0, 3) == 0);
            oe2_n = ($urandom_range(0, 3) == 0);
            d_in  = 8'($urandom);
            cyc("rand");
            if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ls299_shift_reg.md
Name: ls299_shift_reg

Overview:
- Cycle-accurate model of a 74LS299 8-bit universal shift/storage register for the discrete-logic TTL library.
- Converts serial bit streams to the parallel 8-bit words consumed by wide decode gates (8-input NAND detectors), and converts parallel words back to serial streams.
- The TTL clock pin `cp` is an ordinary signal sampled by the FPGA system clock and edge-detected internally, so the block drops into a netlist like the physical chip.

Parameters:
- CP_EDGE, default 1: 1 = act on the rising edge of `cp`; 0 = treat `cp` as a clock enable, acting on every clk where cp=1.

Ports:
- clk, in, 1: FPGA system clock; all state updates on its rising edge.
- rst_n, in, 1: asynchronous active-low reset; models the chip's MR_n pin.
- cp, in, 1: TTL clock pin, sampled on clk.
- s0, in, 1: mode select bit 0.
- s1, in, 1: mode select bit 1.
- ds0, in, 1: serial data in for shift right (enters at q[0]).
- ds7, in, 1: serial data in for shift left (enters at q[7]).
- oe1_n, in, 1: output enable 1, active low.
- oe2_n, in, 1: output enable 2, active low.
- d_in, in, 8: parallel load data (input half of the chip's I/O0-I/O7 pins).
- q_out, out, 8: register contents driven to the I/O pins.
- q_oe, out, 1: 1 = q_out is actively driven; 0 = pins are high-Z (the parent muxes).
- q0, out, 1: serial output, bit 0; always valid.
- q7, out, 1: serial output, bit 7; always valid.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - reg = 8'h00, cp_prev = 1.
  - Outputs: q_out=0, q0=0, q7=0; q_oe follows its combinational equation.
  - Reset mid-shift aborts the operation immediately. No edge is acted on while rst_n=0.
  - cp_prev resets to 1 so that cp already high at reset release does not create a false edge.
- Event detection:
  - CP_EDGE=1: event = cp & ~cp_prev, where cp_prev is cp registered every clk.
  - CP_EDGE=0: event = cp.
  - The event is evaluated and acted on in the same clk cycle. The new contents are visible on q_out, q0 and q7 one clk after the cycle in which cp is sampled high (after being low).
- Mode table, applied only on an event; mode and data inputs are sampled on the event clk:
  - s1s0=00, hold: reg unchanged.
  - s1s0=01, shift right: reg[0]<=ds0, reg[n]<=reg[n-1] for n=1..7; the old reg[7] is discarded.
  - s1s0=10, shift left: reg[7]<=ds7, reg[n]<=reg[n+1] for n=0..6; the old reg[0] is discarded.
  - s1s0=11, parallel load: reg<=d_in.
- No event: reg holds regardless of mode.
- Output enable:
  - q_oe = ~oe1_n & ~oe2_n & ~(s1&s0), combinational.
  - Forcing q_oe=0 in load mode models the chip's I/O pins turning into inputs.
  - q_out always reflects reg; q_oe only qualifies it.
- Serial outputs: q0=reg[0] and q7=reg[7], unaffected by the enables. These pins cascade chips (q7 to ds0 of the next stage for right shifts).
- Mode change coincident with an event: the mode sampled on that clk applies.
- cp held high for many clk (CP_EDGE=1): exactly one operation.
- Glitch (cp high for one clk): counts as one edge.

Test Plan:
- Reset/hold: assert rst_n=0 asynchronously mid-cycle -> q_out=00, q0=0, q7=0 immediately. Release with cp=1 and s=11, d_in=FF -> reg stays 00 until cp goes 0 then 1.
- Load and enable: s=11, d_in=A5, pulse cp -> q_out=A5 one clk after cp high, q_oe=0 while s=11. Set s=00, oe1_n=oe2_n=0 -> q_oe=1, q_out=A5. Set oe2_n=1 -> q_oe=0.
- Shift right: load 00, s=01, ds0=1, 8 cp pulses -> q_out=01,03,07,...,FF. q7 rises on the 8th pulse.
- Shift left: load 80, s=10, ds7=0, 8 pulses -> 40,20,...,01,00. q0=1 after the 7th pulse and 0 after the 8th.
- Edge semantics: CP_EDGE=1 with cp held high 20 clk in shift-right mode -> exactly one shift. CP_EDGE=0, same stimulus -> 20 shifts, so load 01 then s=01, ds0=0 gives 00 after 8 clk.
- Cascade/all-ones: drive ds0 from a bit pattern 1,1,1,1,1,1,1,1 with s=01 -> after 8 edges q_out=FF, so an 8-input NAND on q_out would output 0. A 9th edge with ds0=0 -> FE.
